// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: opcodes, FSM states, instruction fields and ALU ops
// shared by the register-file sequencer and its ALU.
package reg_seq_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_e;

    function automatic alu_op_e alu_op_of(input logic [3:0] opc);
        alu_op_e op;
        op = ALU_ADD;
        case (opc)
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_seq_alu.sv
// reg_seq_alu: combinational ADD/SUB/AND/OR, modulo 2^DATA_W, no flags.
module reg_seq_alu
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/reg_seq_controller.sv
// reg_seq_controller: multi-cycle fetch/decode/exec/mem/wb sequencer.
// Define REG_SEQ_PERF_CNT_EN to enable the retired-instruction counter.
module reg_seq_controller
    import reg_seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_ready,
    input  logic [15:0]       instr_data,
    output logic              ram_req,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        rf_read_addr1,
    output logic [2:0]        rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [2:0]        rf_write_addr,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              halted,
    output logic              illegal_op,
    output logic [15:0]       retired_count
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ill_q, ill_d;

    logic              retire;
    logic              instr_req_c;
    logic              ram_req_c;
    logic              rf_we_c;
    logic [DATA_W-1:0] alu_y;

    logic [3:0] opc;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       is_alu;
    logic       is_mem;
    logic       is_store;
    logic       is_legal;

    assign opc      = instr_q[OPC_HI:OPC_LO];
    assign rd       = instr_q[RD_HI:RD_LO];
    assign rs1      = instr_q[RS1_HI:RS1_LO];
    assign rs2      = instr_q[RS2_HI:RS2_LO];
    assign is_alu   = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign is_store = (opc == OP_STORE);
    assign is_mem   = (opc == OP_LOAD) || is_store;
    assign is_legal = is_alu || is_mem ||
                      (opc inside {OP_NOP, OP_JMP, OP_HALT});

    reg_seq_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_i(alu_op_of(opc)),
        .a_i (op1_q),
        .b_i (op2_q),
        .y_o (alu_y)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        res_d         = res_q;
        ill_d         = ill_q;
        retire        = 1'b0;
        instr_req_c   = 1'b0;
        ram_req_c     = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        rf_read_addr1 = '0;
        rf_read_addr2 = '0;
        rf_we_c       = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        unique case (state_q)
            S_FETCH: begin
                instr_req_c = 1'b1;
                if (instr_ready) begin
                    instr_d = instr_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rf_read_addr1 = rs1;
                rf_read_addr2 = is_store ? rd : rs2;
                op1_d         = rf_read_data1;
                op2_d         = rf_read_data2;
                state_d       = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_alu: begin
                        res_d   = alu_y;
                        state_d = S_WB;
                    end
                    is_mem: state_d = S_MEM;
                    (opc == OP_JMP): begin
                        pc_d    = instr_q[PC_W-1:0];
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    (opc == OP_HALT): begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        ill_d   = ill_q | ~is_legal;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                ram_req_c = 1'b1;
                ram_addr  = op1_q;
                ram_we    = is_store;
                ram_wdata = is_store ? op2_q : '0;
                if (ram_ready) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = ram_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c       = 1'b1;
                rf_write_addr = rd;
                rf_write_data = res_q;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts.
    assign instr_req       = instr_req_c & rst_n;
    assign ram_req         = ram_req_c & rst_n;
    assign rf_write_enable = rf_we_c & rst_n;
    assign instr_addr      = pc_q;
    assign halted          = (state_q == S_HALT);
    assign illegal_op      = ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

`ifdef REG_SEQ_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = retire ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retired_count = cnt_q;
`else
    logic unused_retire;

    assign unused_retire = retire;
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_reg_seq_controller.sv
// tb_reg_seq_controller: directed program run against bench models of
// instruction memory, data RAM and a falling-edge register file.
module tb_reg_seq_controller;

    logic        clk;
    logic        rst_n;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ready;
    logic [15:0] ram_rdata;
    logic [2:0]  rf_read_addr1;
    logic [2:0]  rf_read_addr2;
    logic [15:0] rf_read_data1;
    logic [15:0] rf_read_data2;
    logic [2:0]  rf_write_addr;
    logic        rf_write_enable;
    logic [15:0] rf_write_data;
    logic        halted;
    logic        illegal_op;
    logic [15:0] retired_count;

    reg_seq_controller #(
        .PC_W  (8),
        .DATA_W(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req      (instr_req),
        .instr_addr     (instr_addr),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_ready      (ram_ready),
        .ram_rdata      (ram_rdata),
        .rf_read_addr1  (rf_read_addr1),
        .rf_read_addr2  (rf_read_addr2),
        .rf_read_data1  (rf_read_data1),
        .rf_read_data2  (rf_read_data2),
        .rf_write_addr  (rf_write_addr),
        .rf_write_enable(rf_write_enable),
        .rf_write_data  (rf_write_data),
        .halted         (halted),
        .illegal_op     (illegal_op),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] imem [256];
    logic [15:0] rf [8];
    int          n_assert = 0;
    int          n_fail   = 0;

    int          icnt      = 0;
    int          rcnt      = 0;
    int          load_dly  = 5;
    int          late_n    = 0;
    int          dbl_we    = 0;
    int          post_halt = 0;
    logic        we_prev   = 1'b0;
    logic [15:0] ra0, rd0;
    logic        rw0, stab;

    logic [7:0]  fa_q[$];
    logic [2:0]  wa_q[$];
    logic [15:0] wd_q[$];
    logic [15:0] ma_q[$];
    logic        mw_q[$];
    logic [15:0] md_q[$];
    int          mc_q[$];
    logic        ms_q[$];

    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];

    always @(negedge clk) begin : mon
        if (rf_write_enable) begin
            wa_q.push_back(rf_write_addr);
            wd_q.push_back(rf_write_data);
            rf[rf_write_addr] = rf_write_data;
            if (we_prev) dbl_we++;
        end
        we_prev = rf_write_enable;
        if (halted && (instr_req || ram_req)) post_halt++;
    end

    always @(negedge clk) begin : iresp
        if (instr_req) begin
            if (icnt == 1) begin
                instr_ready = 1'b1;
                instr_data  = imem[instr_addr];
                fa_q.push_back(instr_addr);
            end else begin
                instr_ready = 1'b0;
            end
            icnt++;
        end else begin
            instr_ready = 1'b0;
            icnt = 0;
        end
    end

    always @(negedge clk) begin : rresp
        if (ram_req) begin
            if (rcnt == 0) begin
                ra0  = ram_addr;
                rw0  = ram_we;
                rd0  = ram_wdata;
                stab = 1'b1;
            end else if (ram_addr !== ra0 || ram_we !== rw0 ||
                         ram_wdata !== rd0) begin
                stab = 1'b0;
            end
            // Stores answer after 1 cycle, loads after load_dly.
            if (rcnt == (ram_we ? 1 : load_dly)) begin
                ram_ready = 1'b1;
                ram_rdata = 16'd75;
                ma_q.push_back(ra0);
                mw_q.push_back(rw0);
                md_q.push_back(rd0);
                mc_q.push_back(rcnt + 1);
                ms_q.push_back(stab);
            end else begin
                ram_ready = 1'b0;
            end
            rcnt++;
        end else begin
            rcnt = 0;
            if (late_n > 0) begin
                ram_ready = 1'b1;
                ram_rdata = 16'hDEAD;
                late_n--;
            end else begin
                ram_ready = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        fa_q.delete();
        wa_q.delete();
        wd_q.delete();
        ma_q.delete();
        mw_q.delete();
        md_q.delete();
        mc_q.delete();
        ms_q.delete();
    endtask

    initial begin : main
        int t;
        int nw;
        logic [15:0] exp_cnt;
        logic [2:0]  ew_a [5];
        logic [15:0] ew_d [5];

        ew_a = '{3'd3, 3'd5, 3'd5, 3'd4, 3'd1};
        ew_d = '{16'd3, 16'd6, 16'd7, 16'hFFFF, 16'd75};
        for (int i = 0; i < 8; i++) rf[i] = 16'(i);
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0] = 16'h3650;
        imem[1] = 16'h5BB8;
        imem[2] = 16'h6BB8;
        imem[3] = 16'h28C0;
        imem[4] = 16'h4850;
        imem[5] = 16'h1280;
        imem[6] = 16'h70FE;
        instr_ready = 1'b0;
        instr_data  = '0;
        ram_ready   = 1'b0;
        ram_rdata   = '0;
        rst_n       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr_req", instr_req, 0);
        chk("rst_instr_addr", instr_addr, 0);
        chk("rst_ram_req", ram_req, 0);
        chk("rst_rf_we", rf_write_enable, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_retired", retired_count, 0);

        @(negedge clk);
        #2 rst_n = 1'b1;
        t = 0;
        while (fa_q.size() < 10 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("fetch_n", fa_q.size(), 10);
        chk("pc_after_add", fa_q[1], 1);
        chk("jmp_target", fa_q[7], 8'hFE);
        chk("pc_ff", fa_q[8], 8'hFF);
        chk("pc_wrap", fa_q[9], 0);
        chk("wr_n", wa_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_addr%0d", i), wa_q[i], ew_a[i]);
            chk($sformatf("wr_data%0d", i), wd_q[i], ew_d[i]);
        end
        chk("we_one_cycle", dbl_we, 0);
        chk("mem_n", ma_q.size(), 2);
        chk("st_addr", ma_q[0], 3);
        chk("st_we", mw_q[0], 1);
        chk("st_wdata", md_q[0], 4);
        chk("st_cycles", mc_q[0], 2);
        chk("ld_addr", ma_q[1], 2);
        chk("ld_we", mw_q[1], 0);
        chk("ld_cycles", mc_q[1], 6);
        chk("ld_stable", ms_q[1], 1);
        chk("a_illegal", illegal_op, 0);
        chk("a_halted", halted, 0);

        @(negedge clk);
        #2 rst_n = 1'b0;
        imem[0]  = 16'h1280;
        load_dly = 20;
        clear_logs();
        @(negedge clk);
        #2 rst_n = 1'b1;
        t = 0;
        while (!ram_req && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("mem_reached", ram_req, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        late_n = 4;
        #1;
        chk("rstmem_ram_req", ram_req, 0);
        chk("rstmem_ram_addr", ram_addr, 0);
        chk("rstmem_instr_req", instr_req, 0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nw = wa_q.size();
        fa_q.delete();
        load_dly = 1;
        repeat (3) @(negedge clk);
        chk("late_ready_wr", wa_q.size(), nw);
        chk("late_ready_mem", ma_q.size(), 0);
        t = 0;
        while (fa_q.size() < 1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("restart_fetch_n", fa_q.size(), 1);
        chk("restart_pc", fa_q[0], 0);

        @(negedge clk);
        #2 rst_n = 1'b0;
        imem[0]   = 16'h9000;
        imem[1]   = 16'hF000;
        post_halt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        t = 0;
        while (!halted && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("halted", halted, 1);
        chk("illegal_op", illegal_op, 1);
`ifdef REG_SEQ_PERF_CNT_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        chk("retired_count", retired_count, exp_cnt);
        repeat (10) @(negedge clk);
        chk("halt_no_req", post_halt, 0);
        chk("halt_instr_req", instr_req, 0);
        chk("halt_stays", halted, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
